// File: rtl/axi_riscv_res_table.sv
// LR/SC reservation table for an AXI RISC-V atomics adapter.
// Tracks up to NUM_SLOTS reservations (owner id + granule address + lifetime),
// answers store-conditional queries with a single buffered response, and drops
// reservations on matching SCs, snooped writes, or when their lifetime ends.
module axi_riscv_res_table #(
    parameter int NUM_SLOTS  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int GRAN_LOG2  = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    // Load-reserved port
    input  logic                             lr_valid_i,
    output logic                             lr_ready_o,
    input  logic [ID_WIDTH-1:0]              lr_id_i,
    input  logic [ADDR_WIDTH-1:0]            lr_addr_i,
    // Store-conditional request port
    input  logic                             sc_valid_i,
    output logic                             sc_ready_o,
    input  logic [ID_WIDTH-1:0]              sc_id_i,
    input  logic [ADDR_WIDTH-1:0]            sc_addr_i,
    // Store-conditional response port
    output logic                             sc_rsp_valid_o,
    input  logic                             sc_rsp_ready_i,
    output logic                             sc_rsp_ok_o,
    // Write snoop port
    input  logic                             wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
    // Status
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy_o
);

    localparam int GRAN_W = ADDR_WIDTH - GRAN_LOG2;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PTR_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int OCC_W  = $clog2(NUM_SLOTS + 1);

    // Entry state
    logic [NUM_SLOTS-1:0] entryValid_q, entryValid_d;
    logic [ID_WIDTH-1:0]  entryId_q   [NUM_SLOTS];
    logic [ID_WIDTH-1:0]  entryId_d   [NUM_SLOTS];
    logic [GRAN_W-1:0]    entryGran_q [NUM_SLOTS];
    logic [GRAN_W-1:0]    entryGran_d [NUM_SLOTS];
    logic [CNT_W-1:0]     entryCnt_q  [NUM_SLOTS];
    logic [CNT_W-1:0]     entryCnt_d  [NUM_SLOTS];
    logic [PTR_W-1:0]     rrPtr_q, rrPtr_d;

    // Response buffer
    logic                 rspValid_q;
    logic                 rspOk_q;

    // Request decode
    logic [GRAN_W-1:0]    lrGran, scGran, wrGran;
    logic                 lrAccept, scAccept;
    logic                 scHit;
    logic                 slotFound;
    logic [PTR_W-1:0]     slotIdx;
    logic [OCC_W-1:0]     occCount;

    assign lrGran = lr_addr_i[ADDR_WIDTH-1:GRAN_LOG2];
    assign scGran = sc_addr_i[ADDR_WIDTH-1:GRAN_LOG2];
    assign wrGran = wr_addr_i[ADDR_WIDTH-1:GRAN_LOG2];

    // Address bits below the granule never take part in a compare.
    if (GRAN_LOG2 > 0) begin : gLowBits
        logic unusedLowBits;
        assign unusedLowBits = ^{lr_addr_i[GRAN_LOG2-1:0],
                                 sc_addr_i[GRAN_LOG2-1:0],
                                 wr_addr_i[GRAN_LOG2-1:0]};
    end

    assign lr_ready_o     = ~rst_i;
    assign sc_ready_o     = ~rspValid_q | sc_rsp_ready_i;
    assign lrAccept       = lr_valid_i & lr_ready_o;
    assign scAccept       = sc_valid_i & sc_ready_o;
    assign sc_rsp_valid_o = rspValid_q;
    assign sc_rsp_ok_o    = rspOk_q;
    assign occupancy_o    = occCount;

    // SC succeeds only against the table as it stood at the start of the cycle.
    always_comb begin
        scHit = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (entryValid_q[i] && (entryId_q[i] == sc_id_i) && (entryGran_q[i] == scGran)) begin
                scHit = 1'b1;
            end
        end
    end

    // Next entry state: age/expire, apply SC and write kills, then place the LR.
    always_comb begin
        entryValid_d = entryValid_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            entryId_d[i]   = entryId_q[i];
            entryGran_d[i] = entryGran_q[i];
            entryCnt_d[i]  = entryCnt_q[i];
        end
        rrPtr_d   = rrPtr_q;
        slotFound = 1'b0;
        slotIdx   = '0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((TIMEOUT > 0) && entryValid_q[i]) begin
                if (entryCnt_q[i] == CNT_W'(1)) begin
                    entryValid_d[i] = 1'b0;
                end
                entryCnt_d[i] = entryCnt_q[i] - CNT_W'(1);
            end
            if (scAccept && entryValid_q[i] && (entryId_q[i] == sc_id_i)) begin
                entryValid_d[i] = 1'b0;
            end
            if (wr_valid_i && (entryGran_q[i] == wrGran)) begin
                entryValid_d[i] = 1'b0;
            end
        end

        if (lrAccept) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!slotFound && entryValid_d[i] && (entryId_q[i] == lr_id_i)) begin
                    slotFound = 1'b1;
                    slotIdx   = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (!slotFound && !entryValid_d[i]) begin
                    slotFound = 1'b1;
                    slotIdx   = PTR_W'(i);
                end
            end
            if (!slotFound) begin
                slotIdx = rrPtr_q;
                rrPtr_d = (rrPtr_q == PTR_W'(NUM_SLOTS - 1)) ? '0 : rrPtr_q + PTR_W'(1);
            end
            entryValid_d[slotIdx] = 1'b1;
            entryId_d[slotIdx]    = lr_id_i;
            entryGran_d[slotIdx]  = lrGran;
            entryCnt_d[slotIdx]   = CNT_W'(TIMEOUT);
        end
    end

    // Count of live reservations, taken straight from the registered valid bits.
    always_comb begin
        occCount = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occCount = occCount + OCC_W'(entryValid_q[i]);
        end
    end

    // Entry and round-robin pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entryValid_q <= '0;
            rrPtr_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                entryId_q[i]   <= '0;
                entryGran_q[i] <= '0;
                entryCnt_q[i]  <= '0;
            end
        end else begin
            entryValid_q <= entryValid_d;
            rrPtr_q      <= rrPtr_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                entryId_q[i]   <= entryId_d[i];
                entryGran_q[i] <= entryGran_d[i];
                entryCnt_q[i]  <= entryCnt_d[i];
            end
        end
    end

    // Single-entry SC response buffer; a new SC may replace it in the cycle it drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rspValid_q <= 1'b0;
            rspOk_q    <= 1'b0;
        end else if (scAccept) begin
            rspValid_q <= 1'b1;
            rspOk_q    <= scHit;
        end else if (sc_rsp_ready_i) begin
            rspValid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_riscv_res_table.sv
// Self-checking bench for the LR/SC reservation table.
// Table-driven cycle vectors plus hand-written sequences for lifetime expiry,
// response back-pressure and reset during a pending response.
module tb_axi_riscv_res_table;

    logic        clk_i;
    logic        rst_i;
    logic        lr_valid_i;
    logic        lr_ready_o;
    logic [7:0]  lr_id_i;
    logic [63:0] lr_addr_i;
    logic        sc_valid_i;
    logic        sc_ready_o;
    logic [7:0]  sc_id_i;
    logic [63:0] sc_addr_i;
    logic        sc_rsp_valid_o;
    logic        sc_rsp_ready_i;
    logic        sc_rsp_ok_o;
    logic        wr_valid_i;
    logic [63:0] wr_addr_i;
    logic [2:0]  occupancy_o;

    axi_riscv_res_table #(
        .NUM_SLOTS (4),
        .ADDR_WIDTH(64),
        .ID_WIDTH  (8),
        .GRAN_LOG2 (3),
        .TIMEOUT   (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lr_valid_i    (lr_valid_i),
        .lr_ready_o    (lr_ready_o),
        .lr_id_i       (lr_id_i),
        .lr_addr_i     (lr_addr_i),
        .sc_valid_i    (sc_valid_i),
        .sc_ready_o    (sc_ready_o),
        .sc_id_i       (sc_id_i),
        .sc_addr_i     (sc_addr_i),
        .sc_rsp_valid_o(sc_rsp_valid_o),
        .sc_rsp_ready_i(sc_rsp_ready_i),
        .sc_rsp_ok_o   (sc_rsp_ok_o),
        .wr_valid_i    (wr_valid_i),
        .wr_addr_i     (wr_addr_i),
        .occupancy_o   (occupancy_o)
    );

    // One cycle of stimulus and the occupancy expected after its clock edge.
    typedef struct packed {
        bit          doReset;
        bit          lrV;
        logic [7:0]  lrId;
        logic [63:0] lrAddr;
        bit          scV;
        logic [7:0]  scId;
        logic [63:0] scAddr;
        bit          wrV;
        logic [63:0] wrAddr;
        bit          expOk;
        logic [2:0]  expOcc;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    bit   expQ[$];
    bit   expRspValid = 1'b0;
    vec_t vecs[$];
    vec_t idleVec;

    // Free-running clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard stop in case something stalls the main sequence.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input bit r, input bit lrV, input logic [7:0] lrId,
                                input logic [63:0] lrAddr, input bit scV, input logic [7:0] scId,
                                input logic [63:0] scAddr, input bit wrV, input logic [63:0] wrAddr,
                                input bit ok, input int occ);
        vec_t v;
        v.doReset = r;
        v.lrV     = lrV;
        v.lrId    = lrId;
        v.lrAddr  = lrAddr;
        v.scV     = scV;
        v.scId    = scId;
        v.scAddr  = scAddr;
        v.wrV     = wrV;
        v.wrAddr  = wrAddr;
        v.expOk   = ok;
        v.expOcc  = 3'(occ);
        return v;
    endfunction

    function automatic vec_t lrRow(input bit r, input int id, input logic [63:0] a, input int occ);
        return mk(r, 1'b1, 8'(id), a, 1'b0, 8'd0, 64'd0, 1'b0, 64'd0, 1'b0, occ);
    endfunction

    function automatic vec_t scRow(input int id, input logic [63:0] a, input bit ok, input int occ);
        return mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b1, 8'(id), a, 1'b0, 64'd0, ok, occ);
    endfunction

    function automatic vec_t wrRow(input logic [63:0] a, input int occ);
        return mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0, 1'b1, a, 1'b0, occ);
    endfunction

    function automatic vec_t lrWrRow(input bit r, input int id, input logic [63:0] a,
                                     input logic [63:0] wa, input int occ);
        return mk(r, 1'b1, 8'(id), a, 1'b0, 8'd0, 64'd0, 1'b1, wa, 1'b0, occ);
    endfunction

    function automatic vec_t idleRow(input int occ);
        return mk(1'b0, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0, 1'b0, 64'd0, 1'b0, occ);
    endfunction

    task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Async reset: outputs must clear at once; any buffered response is dropped.
    task automatic doReset();
        rst_i          = 1'b1;
        lr_valid_i     = 1'b0;
        sc_valid_i     = 1'b0;
        wr_valid_i     = 1'b0;
        sc_rsp_ready_i = 1'b0;
        #2;
        compareValue("reset lr_ready", lr_ready_o, 0);
        compareValue("reset occupancy", occupancy_o, 0);
        compareValue("reset rsp_valid", sc_rsp_valid_o, 0);
        expQ.delete();
        expRspValid = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Drive one cycle; check ready and any response handshake, then clock.
    task automatic applyStimulus(input vec_t v, input bit rspRdy);
        bit expReady;
        bit accepted;
        lr_valid_i     = v.lrV;
        lr_id_i        = v.lrId;
        lr_addr_i      = v.lrAddr;
        sc_valid_i     = v.scV;
        sc_id_i        = v.scId;
        sc_addr_i      = v.scAddr;
        wr_valid_i     = v.wrV;
        wr_addr_i      = v.wrAddr;
        sc_rsp_ready_i = rspRdy;
        #2;
        expReady = !expRspValid || rspRdy;
        compareValue("lr_ready", lr_ready_o, 1);
        compareValue("sc_ready", sc_ready_o, 64'(expReady));
        if (sc_rsp_valid_o && rspRdy) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sc_rsp_unexpected: got rsp_valid 1, expected no response");
            end else begin
                compareValue("sc_rsp_ok", sc_rsp_ok_o, 64'(expQ.pop_front()));
            end
        end else if (sc_rsp_valid_o && expQ.size() > 0) begin
            compareValue("sc_rsp_ok_hold", sc_rsp_ok_o, 64'(expQ[0]));
        end
        accepted = v.scV && expReady;
        if (accepted) expQ.push_back(v.expOk);
        expRspValid = accepted || (expRspValid && !rspRdy);
        @(posedge clk_i);
        #1;
    endtask

    // Post-edge registered state.
    task automatic checkOutput(input logic [2:0] expOcc);
        compareValue("occupancy", occupancy_o, 64'(expOcc));
        compareValue("rsp_valid", sc_rsp_valid_o, 64'(expRspValid));
    endtask

    initial begin
        idleVec = idleRow(0);
        lr_id_i = '0; lr_addr_i = '0; sc_id_i = '0; sc_addr_i = '0; wr_addr_i = '0;

        // Basic LR then SC five cycles later; the repeat finds nothing.
        vecs.push_back(lrRow(1'b1, 3, 64'h1000, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(idleRow(1));
        vecs.push_back(scRow(3, 64'h1004, 1'b1, 0));
        vecs.push_back(scRow(3, 64'h1004, 1'b0, 0));
        vecs.push_back(idleRow(0));
        // Snooped write inside the granule kills; one granule over does not.
        vecs.push_back(lrRow(1'b1, 1, 64'h2000, 1));
        vecs.push_back(wrRow(64'h2007, 0));
        vecs.push_back(scRow(1, 64'h2000, 1'b0, 0));
        vecs.push_back(lrRow(1'b0, 1, 64'h2000, 1));
        vecs.push_back(wrRow(64'h2008, 1));
        vecs.push_back(scRow(1, 64'h2000, 1'b1, 0));
        vecs.push_back(idleRow(0));
        // Fill, evict via round-robin, same-id rewrite, pointer advance.
        vecs.push_back(lrRow(1'b1, 0, 64'h100, 1));
        vecs.push_back(lrRow(1'b0, 1, 64'h200, 2));
        vecs.push_back(lrRow(1'b0, 2, 64'h300, 3));
        vecs.push_back(lrRow(1'b0, 3, 64'h400, 4));
        vecs.push_back(lrRow(1'b0, 4, 64'h500, 4));
        vecs.push_back(scRow(0, 64'h100, 1'b0, 4));
        vecs.push_back(scRow(1, 64'h200, 1'b1, 3));
        vecs.push_back(lrRow(1'b0, 2, 64'h380, 3));
        vecs.push_back(scRow(2, 64'h300, 1'b0, 2));
        vecs.push_back(lrRow(1'b0, 5, 64'h600, 3));
        vecs.push_back(lrRow(1'b0, 6, 64'h700, 4));
        vecs.push_back(lrRow(1'b0, 7, 64'h800, 4));
        vecs.push_back(scRow(5, 64'h600, 1'b0, 4));
        vecs.push_back(scRow(4, 64'h500, 1'b1, 3));
        vecs.push_back(idleRow(3));
        // LR survives a same-cycle write; slot choice uses post-kill valid bits.
        vecs.push_back(lrWrRow(1'b1, 9, 64'h900, 64'h900, 1));
        vecs.push_back(scRow(9, 64'h900, 1'b1, 0));
        vecs.push_back(lrRow(1'b0, 10, 64'hA00, 1));
        vecs.push_back(lrRow(1'b0, 11, 64'hB00, 2));
        vecs.push_back(lrRow(1'b0, 12, 64'hC00, 3));
        vecs.push_back(lrRow(1'b0, 13, 64'hD00, 4));
        vecs.push_back(lrWrRow(1'b0, 14, 64'hE00, 64'hB00, 4));
        vecs.push_back(lrRow(1'b0, 15, 64'hF00, 4));
        vecs.push_back(scRow(10, 64'hA00, 1'b0, 4));
        vecs.push_back(scRow(12, 64'hC00, 1'b1, 3));
        vecs.push_back(scRow(14, 64'hE00, 1'b1, 2));
        vecs.push_back(idleRow(2));

        rst_i = 1'b1;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) doReset();
            applyStimulus(vecs[i], 1'b1);
            checkOutput(vecs[i].expOcc);
        end

        // Lifetime: entry aged 15 cycles (counter at 1) still grants the SC.
        doReset();
        applyStimulus(lrRow(1'b0, 2, 64'h40, 1), 1'b1);
        checkOutput(1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(idleVec, 1'b1);
            checkOutput(1);
        end
        applyStimulus(scRow(2, 64'h40, 1'b1, 0), 1'b1);
        checkOutput(0);
        applyStimulus(idleVec, 1'b1);
        checkOutput(0);

        // Lifetime: one cycle older and the reservation has expired.
        doReset();
        applyStimulus(lrRow(1'b0, 2, 64'h40, 1), 1'b1);
        checkOutput(1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(idleVec, 1'b1);
            checkOutput((i == 15) ? 3'd0 : 3'd1);
        end
        applyStimulus(scRow(2, 64'h40, 1'b0, 0), 1'b1);
        checkOutput(0);
        applyStimulus(idleVec, 1'b1);
        checkOutput(0);

        // SC and LR of the same id together, response held under back-pressure.
        doReset();
        applyStimulus(lrRow(1'b0, 5, 64'h500, 1), 1'b1);
        checkOutput(1);
        applyStimulus(mk(1'b0, 1'b1, 8'd5, 64'h5A0, 1'b1, 8'd5, 64'h500, 1'b0, 64'd0, 1'b1, 1), 1'b1);
        checkOutput(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(scRow(5, 64'h5A0, 1'b1, 1), 1'b0);
            checkOutput(1);
        end
        applyStimulus(scRow(5, 64'h5A0, 1'b1, 0), 1'b1);
        checkOutput(0);
        applyStimulus(idleVec, 1'b1);
        checkOutput(0);

        // Reset while a response is pending and three entries are live.
        doReset();
        applyStimulus(lrRow(1'b0, 1, 64'h100, 1), 1'b1);
        checkOutput(1);
        applyStimulus(lrRow(1'b0, 2, 64'h200, 2), 1'b1);
        checkOutput(2);
        applyStimulus(lrRow(1'b0, 3, 64'h300, 3), 1'b1);
        checkOutput(3);
        applyStimulus(scRow(7, 64'h700, 1'b0, 3), 1'b1);
        checkOutput(3);
        applyStimulus(idleRow(3), 1'b0);
        checkOutput(3);
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idleVec, 1'b1);
            checkOutput(0);
        end

        compareValue("scoreboard drained", 64'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
